// File: rtl/router_ingress.sv
`default_nettype none
// router_ingress: DEPTH-entry packet FIFO feeding an IDLE/DECODE/ROUTE/STORE router handshake FSM.
// Optional macro ROUTER_INGRESS_TYPE_FILTER_EN drops type==2'b11 packets and counts them on filt_count_o.
// Revision: 1.0
module router_ingress #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  input  logic [12:0]            in_packet_i,
  output logic                   in_ready_o,
  output logic [12:0]            packet_o,
  output logic                   decode_o,
  output logic                   routing_o,
  output logic                   buffer_enable_o,
  input  logic                   router_ack_i,
  input  logic                   router_available_i,
  output logic [$clog2(DEPTH):0] fifo_count_o,
`ifdef ROUTER_INGRESS_TYPE_FILTER_EN
  output logic [7:0]             filt_count_o,
`endif
  output logic                   err_timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL_CNT     = CW'(DEPTH);
  localparam logic [TW-1:0] WAIT_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ROUTE  = 2'd2,
    STORE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [12:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [TW-1:0]   wait_q;
  logic            decode_q;
  logic            routing_q;
  logic            buffer_q;
  logic            err_q;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_timeout;

  // Full is judged from the registered count, so a pop in the same cycle never frees a slot early.
  assign in_ready_o = (count_q < FULL_CNT);
  assign w_accept   = in_valid_i && in_ready_o;

`ifdef ROUTER_INGRESS_TYPE_FILTER_EN
  logic       w_drop;
  logic [7:0] filt_q;

  assign w_drop = w_accept && (in_packet_i[10:9] == 2'b11);
  assign w_push = w_accept && !w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
    end else if (w_drop && (filt_q != 8'hFF)) begin
      filt_q <= filt_q + 8'd1;
    end
  end

  assign filt_count_o = filt_q;
`else
  assign w_push = w_accept;
`endif

  // Ack at the final wait cycle still wins over the timeout.
  assign w_timeout = (state_q == ROUTE) && !router_ack_i && (wait_q == WAIT_LAST);
  assign w_pop     = (state_q == STORE) || w_timeout;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CW'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_packet_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      decode_q  <= 1'b0;
      routing_q <= 1'b0;
      buffer_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      decode_q  <= 1'b0;
      routing_q <= 1'b0;
      buffer_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((count_q != '0) && router_available_i) begin
            state_q  <= DECODE;
            decode_q <= 1'b1;
          end
        end
        DECODE: begin
          state_q   <= ROUTE;
          routing_q <= 1'b1;
          wait_q    <= '0;
        end
        ROUTE: begin
          if (router_ack_i) begin
            state_q  <= STORE;
            buffer_q <= 1'b1;
          end else if (w_timeout) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            wait_q    <= wait_q + TW'(1);
            routing_q <= 1'b1;
          end
        end
        STORE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign packet_o        = (count_q != '0) ? mem_q[rd_ptr_q] : 13'd0;
  assign fifo_count_o    = count_q;
  assign decode_o        = decode_q;
  assign routing_o       = routing_q;
  assign buffer_enable_o = buffer_q;
  assign err_timeout_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_router_ingress.sv
`default_nettype none
// tb_router_ingress: scoreboard bench for router_ingress with a random router agent.
// Revision: 1.0
module tb_router_ingress;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [12:0]   in_packet_i = '0;
  logic          in_ready_o;
  logic [12:0]   packet_o;
  logic          decode_o;
  logic          routing_o;
  logic          buffer_enable_o;
  logic          router_ack_i;
  logic          router_available_i;
  logic [CW-1:0] fifo_count_o;
  logic          err_timeout_o;
`ifdef ROUTER_INGRESS_TYPE_FILTER_EN
  logic [7:0]    filt_count_o;
`endif

  always #5 clk = ~clk;

  router_ingress #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid_i         (in_valid_i),
    .in_packet_i        (in_packet_i),
    .in_ready_o         (in_ready_o),
    .packet_o           (packet_o),
    .decode_o           (decode_o),
    .routing_o          (routing_o),
    .buffer_enable_o    (buffer_enable_o),
    .router_ack_i       (router_ack_i),
    .router_available_i (router_available_i),
    .fifo_count_o       (fifo_count_o),
`ifdef ROUTER_INGRESS_TYPE_FILTER_EN
    .filt_count_o       (filt_count_o),
`endif
    .err_timeout_o      (err_timeout_o)
  );

  typedef struct {
    int len;
    bit to;
  } route_t;

  logic [12:0] exp_q[$];
  route_t      route_q[$];
  int          filt_exp = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  int ack_mode = 1;
  int fixed_d = 2;
  bit spurious_en = 1'b0;
  bit avail_rand = 1'b0;
  bit avail_val = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: packets leave in acceptance order; reserved type is dropped when filtering.
  task automatic model_accept(input logic [12:0] p);
`ifdef ROUTER_INGRESS_TYPE_FILTER_EN
    if (p[10:9] == 2'b11) begin
      if (filt_exp < 255) filt_exp++;
    end else begin
      exp_q.push_back(p);
    end
`else
    exp_q.push_back(p);
`endif
  endtask

  task automatic send(input logic [12:0] p);
    int waitc = 0;
    in_valid_i  = 1'b1;
    in_packet_i = p;
    #1;
    while (!in_ready_o && waitc < 300) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (in_ready_o) model_accept(p);
    else check("send_accept_timeout", in_ready_o, 1);
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic count_cycles(input int n, inout int nd, inout int nr, inout int nb, inout int ne);
    repeat (n) begin
      @(negedge clk);
      #1;
      nd += int'(decode_o);
      nr += int'(routing_o);
      nb += int'(buffer_enable_o);
      ne += int'(err_timeout_o);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || fifo_count_o != '0 || routing_o || buffer_enable_o || decode_o)
           && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check({name, "_drain_sb"}, exp_q.size(), 0);
    check({name, "_drain_count"}, fifo_count_o, 0);
  endtask

  initial begin : avail_driver
    router_available_i = 1'b0;
    forever begin
      @(negedge clk);
      router_available_i = avail_rand ? ($urandom_range(0, 3) != 0) : avail_val;
    end
  end

  // Router agent: acks d cycles into each ROUTE burst and records the burst it expects.
  initial begin : ack_agent
    int idx = 0;
    int d = 0;
    int r = 0;
    bit prev = 1'b0;
    router_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idx = 0;
        prev = 1'b0;
        router_ack_i = 1'b0;
      end else if (routing_o) begin
        if (!prev) begin
          idx = 0;
          if (ack_mode == 1) begin
            d = fixed_d;
          end else begin
            r = $urandom_range(0, 9);
            if (r == 0) d = TIMEOUT + $urandom_range(0, 3);
            else if (r == 1) d = TIMEOUT - 1;
            else d = $urandom_range(0, 4);
          end
          route_q.push_back('{len: (d < TIMEOUT) ? d + 1 : TIMEOUT, to: (d >= TIMEOUT)});
        end else begin
          idx++;
        end
        router_ack_i = (idx == d);
        prev = 1'b1;
      end else begin
        prev = 1'b0;
        router_ack_i = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  initial begin : monitor
    int rt_len = 0;
    bit prev_rt = 1'b0;
    bit prev_dec = 1'b0;
    logic [12:0] cur = '0;
    route_t rexp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        route_q.delete();
        rt_len = 0;
        prev_rt = 1'b0;
        prev_dec = 1'b0;
      end else begin
        check("in_ready_rule", in_ready_o, (fifo_count_o < CW'(DEPTH)));
        if (decode_o) begin
          check("decode_single_cycle", prev_dec, 0);
          check("sb_nonempty_at_decode", (exp_q.size() > 0), 1);
          cur = packet_o;
          if (exp_q.size() > 0) check("packet_order", packet_o, exp_q.pop_front());
        end
        if (routing_o || buffer_enable_o) check("packet_hold", packet_o, cur);
        if (routing_o) begin
          rt_len++;
        end else if (prev_rt) begin
          check("route_sb_nonempty", (route_q.size() > 0), 1);
          if (route_q.size() > 0) begin
            rexp = route_q.pop_front();
            check("route_len", rt_len, rexp.len);
            check("store_after_route", buffer_enable_o, !rexp.to);
            check("timeout_pulse", err_timeout_o, rexp.to);
          end
          rt_len = 0;
        end
        if (err_timeout_o) check("err_only_after_route", prev_rt, 1);
        prev_dec = decode_o;
        prev_rt = routing_o;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int nd, nr, nb, ne;
    logic [12:0] p;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_count", fifo_count_o, 0);
    check("rst_packet", packet_o, 0);
    check("rst_outputs", {decode_o, routing_o, buffer_enable_o, err_timeout_o}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single packet, ack two cycles into ROUTE
    ack_mode = 1; fixed_d = 2; avail_val = 1'b1;
    repeat (2) @(negedge clk);
    send(13'h1A55);
    #1;
    check("t1_idle_after_push", decode_o, 0);
    check("t1_count_one", fifo_count_o, 1);
    @(negedge clk);
    #1;
    check("t1_decode_latency", decode_o, 1);
    check("t1_packet", packet_o, 13'h1A55);
    nd = 1; nr = 0; nb = 0; ne = 0;
    count_cycles(10, nd, nr, nb, ne);
    check("t1_decode_cycles", nd, 1);
    check("t1_routing_cycles", nr, 3);
    check("t1_store_cycles", nb, 1);
    check("t1_no_timeout", ne, 0);
    check("t1_count_zero", fifo_count_o, 0);
    check("t1_packet_empty", packet_o, 0);

    // Fill with router unavailable, fifth push must stall
    fixed_d = 1; avail_val = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send({2'b10, 2'b01, 7'(i + 16), 2'b01});
    #1;
    check("t2_full_not_ready", in_ready_o, 0);
    check("t2_full_count", fifo_count_o, 4);
    p = {2'b01, 2'b10, 7'h55, 2'b11};
    in_valid_i = 1'b1;
    in_packet_i = p;
    repeat (3) @(negedge clk);
    #1;
    check("t2_fifth_held", fifo_count_o, 4);
    avail_val = 1'b1;
    nd = 0;
    while (!in_ready_o && nd < 100) begin
      @(negedge clk);
      #1;
      nd++;
    end
    check("t2_fifth_accepted", in_ready_o, 1);
    if (in_ready_o) model_accept(p);
    @(negedge clk);
    in_valid_i = 1'b0;
    drain("t2", 200);

    // Timeout with ack withheld
    fixed_d = 100;
    send(13'h0ABC);
    nd = 0; nr = 0; nb = 0; ne = 0;
    count_cycles(25, nd, nr, nb, ne);
    check("t3_decode_cycles", nd, 1);
    check("t3_routing_cycles", nr, TIMEOUT);
    check("t3_err_pulses", ne, 1);
    check("t3_no_store", nb, 0);
    check("t3_popped", fifo_count_o, 0);

    // Streaming 0..9 across pointer wrap
    fixed_d = 0;
    for (int i = 0; i < 10; i++) send(13'(i));
    drain("t4", 200);

    // Reset while routing with three packets buffered
    fixed_d = 100;
    for (int i = 0; i < 3; i++) send(13'h0100 + 13'(i));
    #1;
    check("t5_in_route", routing_o, 1);
    check("t5_count_three", fifo_count_o, 3);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_count", fifo_count_o, 0);
    check("t5_rst_ready", in_ready_o, 1);
    check("t5_rst_packet", packet_o, 0);
    check("t5_rst_outputs", {decode_o, routing_o, buffer_enable_o, err_timeout_o}, 0);
    repeat (2) @(negedge clk);
    filt_exp = 0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("t5_post_idle", {decode_o, routing_o, fifo_count_o}, 0);

`ifdef ROUTER_INGRESS_TYPE_FILTER_EN
    // Reserved type is consumed but never reaches the datapath
    fixed_d = 1;
    send({2'b01, 2'b11, 7'h2A, 2'b10});
    #1;
    check("t6_filtered_not_stored", fifo_count_o, 0);
    check("t6_filt_count", filt_count_o, filt_exp);
    send({2'b10, 2'b01, 7'h15, 2'b01});
    drain("t6", 100);
`endif

    // Randomized traffic, availability and ack timing
    ack_mode = 0; spurious_en = 1'b1; avail_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(13'($urandom));
    end
    avail_rand = 1'b0; avail_val = 1'b1;
    drain("t7", 3000);
    check("t7_route_sb_empty", route_q.size(), 0);
`ifdef ROUTER_INGRESS_TYPE_FILTER_EN
    check("t7_filt_count", filt_count_o, filt_exp);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_ingress.md
ROUTER_INGRESS -- requirements
Module: router_ingress

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles spent in ROUTE waiting for router_ack.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers in_packet.
REQ-006 in_packet  input  13  {dest[12:11], type[10:9], payload[8:2], eop[1:0]}.
REQ-007 in_ready  output  1  FIFO can accept; transfer when in_valid && in_ready.
REQ-008 packet  output  13  FIFO head to router datapath; 0 when empty.
REQ-009 decode  output  1  datapath decode strobe.
REQ-010 routing  output  1  datapath routing request.
REQ-011 buffer_enable  output  1  datapath buffer-store strobe.
REQ-012 router_ack  input  1  datapath routing complete.
REQ-013 router_available  input  1  datapath can take a packet.
REQ-014 fifo_count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 err_timeout  output  1  one-cycle pulse on ROUTE timeout.

Function
REQ-016 SHALL buffer packets in a DEPTH-entry FIFO with wrapping read/write pointers.
REQ-017 in_ready SHALL equal (fifo_count < DEPTH), from registered count only; a same-cycle pop SHALL NOT free a slot when full.
REQ-018 Simultaneous push and pop SHALL leave fifo_count unchanged and both pointers advanced.
REQ-019 FSM states: IDLE, DECODE, ROUTE, STORE; decode/routing/buffer_enable SHALL be Moore outputs, high only in DECODE/ROUTE/STORE respectively.
REQ-020 IDLE->DECODE when fifo_count!=0 && router_available=1; else stay IDLE.
REQ-021 DECODE SHALL last exactly 1 cycle, then ->ROUTE.
REQ-022 ROUTE->STORE when router_ack=1 sampled at an edge; ack during IDLE/DECODE/STORE SHALL be ignored.
REQ-023 ROUTE wait counter SHALL clear on entry; if TIMEOUT cycles elapse without ack, SHALL pop head, pulse err_timeout 1 cycle, ->IDLE (STORE skipped).
REQ-024 STORE SHALL last 1 cycle, pop head at its ending edge, ->IDLE.
REQ-025 packet SHALL hold the head stable from DECODE entry through STORE/timeout pop.
REQ-026 Minimum latency: push at edge t into empty FIFO, IDLE, router_available=1 -> decode high in cycle after edge t+1.
REQ-027 Back-to-back packets SHALL cost minimum 4 cycles each (IDLE, DECODE, ROUTE, STORE).
REQ-028 Pointer wrap SHALL be seamless; no data loss at DEPTH boundary.

Reset
REQ-029 On reset low: FSM=IDLE, pointers=0, fifo_count=0, wait counter=0, decode=routing=buffer_enable=0, err_timeout=0, packet=0, in_ready=1.
REQ-030 Reset mid-operation SHALL discard all buffered packets immediately; first clock after deassertion behaves as post-reset IDLE.

Configuration
REQ-031 Macro ROUTER_INGRESS_TYPE_FILTER_EN: when defined, packets with type==2'b11 SHALL be accepted (in_ready honoured) but not written to FIFO, and an 8-bit saturating output filt_count SHALL increment per discarded packet (reset 0, sticks at 255).
REQ-032 Without the macro, all packets SHALL be stored and port filt_count SHALL NOT exist.

Verification
REQ-033 Reset low, then 1 packet 13'h1A55, router_available=1, ack 2 cycles after routing rises -> decode 1 cycle, routing 3 cycles, buffer_enable 1 cycle, packet=13'h1A55 throughout, fifo_count 1->0.
REQ-034 5 pushes, router_available=0, DEPTH=4 -> in_ready=0 after 4th, fifo_count=4, 5th held; then router_available=1 -> packets drain in push order.
REQ-035 Continuous push/pop over 10 packets -> pointer wrap, output order 0..9 matches input, no loss.
REQ-036 router_ack held 0, TIMEOUT=15 -> routing high 15 cycles, err_timeout pulse 1 cycle, head popped, no buffer_enable.
REQ-037 reset low while in ROUTE with fifo_count=3 -> all outputs to reset values same cycle, fifo_count=0, in_ready=1.
REQ-038 With ROUTER_INGRESS_TYPE_FILTER_EN, push type=2'b11 then type=2'b01 -> filt_count=1, only second packet reaches decode.
